maze_cell_tx: RTL and testbench



---
 rtl/maze_cell_tx.sv | 206 ++++++++++++++++++++
 tb/tb_maze_cell_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_cell_tx.sv
`default_nettype none
// ============================================================================
// Module      : maze_cell_tx
// Description : Transmitter for the 9-wire parallel maze-update bus
//               (3 data, 1 strobe, 5 address) decoded by the base-station
//               VGA receiver. Accepts 9-bit cell words over a valid/ready
//               handshake and serialises each one into the 5-strobe frame
//               the receiver's position counter expects. Emits an
//               address-31 sync strobe whenever receiver alignment is
//               unknown, and an address-30 "done" strobe on request.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   STROBE_HALF  cycles per strobe half-period (2..255); one bus slot is
//                2*STROBE_HALF cycles
// Ports
//   CLOCK     in   1  system clock
//   RESET     in   1  asynchronous active-high reset
//   WR_VALID  in   1  cell word offered
//   WR_ADDR   in   5  cell address (0..29; 30/31 reserved)
//   WR_DATA   in   9  [8:6] state, [5:2] walls, [1:0] treasure
//   WR_READY  out  1  idle, able to take a word or a done request
//   DONE_REQ  in   1  request done strobe (level, must be held)
//   ERR       out  1  one-cycle pulse: reserved address was offered
//   BUS_DATA  out  3  bus data bits
//   BUS_CLK   out  1  bus strobe, receiver samples on rising edge
//   BUS_ADDR  out  5  bus address bits
// ============================================================================
module maze_cell_tx #(
    parameter int STROBE_HALF = 4
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       WR_VALID,
    input  logic [4:0] WR_ADDR,
    input  logic [8:0] WR_DATA,
    output logic       WR_READY,
    input  logic       DONE_REQ,
    output logic       ERR,
    output logic [2:0] BUS_DATA,
    output logic       BUS_CLK,
    output logic [4:0] BUS_ADDR
);

    localparam logic [8:0] C_HALF = 9'(STROBE_HALF);
    localparam logic [8:0] C_LAST = 9'(2 * STROBE_HALF - 1);

    localparam logic [4:0] C_ADDR_SYNC = 5'd31;
    localparam logic [4:0] C_ADDR_DONE = 5'd30;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_LEAD = 3'd2,
        ST_D0   = 3'd3,
        ST_D1   = 3'd4,
        ST_D2   = 3'd5,
        ST_TAIL = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    state_t     state_q,      state_d;
    logic [8:0] cnt_q,        cnt_d;
    logic [4:0] addr_q,       addr_d;
    logic [8:0] data_q,       data_d;
    logic       needs_sync_q, needs_sync_d;
    logic       done_sent_q,  done_sent_d;
    logic       ready_q,      ready_d;
    logic       err_q,        err_d;
    logic [4:0] bus_addr_q,   bus_addr_d;
    logic [2:0] bus_data_q,   bus_data_d;
    logic       bus_clk_q,    bus_clk_d;

    // Address/data presented during the slot of the current state
    logic [4:0] slot_addr;
    logic [2:0] slot_data;
    state_t     slot_next;

    always_comb begin
        slot_addr = addr_q;
        slot_data = 3'd0;
        slot_next = ST_IDLE;
        case (state_q)
            ST_SYNC: begin
                slot_addr = C_ADDR_SYNC;
                slot_next = ST_LEAD;
            end
            ST_LEAD: slot_next = ST_D0;
            ST_D0: begin
                slot_data = data_q[2:0];
                slot_next = ST_D1;
            end
            ST_D1: begin
                slot_data = data_q[5:3];
                slot_next = ST_D2;
            end
            ST_D2: begin
                slot_data = data_q[8:6];
                slot_next = ST_TAIL;
            end
            ST_TAIL: slot_next = ST_IDLE;
            ST_DONE: begin
                slot_addr = C_ADDR_DONE;
                slot_next = ST_IDLE;
            end
            default: begin
                slot_addr = addr_q;
                slot_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        needs_sync_d = needs_sync_q;
        done_sent_d  = done_sent_q;
        err_d        = 1'b0;
        bus_addr_d   = bus_addr_q;
        bus_data_d   = bus_data_q;
        bus_clk_d    = bus_clk_q;

        if (state_q == ST_IDLE) begin
            cnt_d     = 9'd0;
            bus_clk_d = 1'b0;
            // A write always takes precedence over a done request
            if (WR_VALID) begin
                if (WR_ADDR >= C_ADDR_DONE) begin
                    err_d = 1'b1;
                end else begin
                    addr_d      = WR_ADDR;
                    data_d      = WR_DATA;
                    done_sent_d = 1'b0;
                    state_d     = needs_sync_q ? ST_SYNC : ST_LEAD;
                end
            end else if (DONE_REQ && !done_sent_q) begin
                // done_sent keeps a held request from re-strobing, so the
                // receiver's done indication stays asserted
                state_d = ST_DONE;
            end
        end else begin
            cnt_d = cnt_q + 9'd1;
            // Bus values are registered on the first edge of the slot,
            // the same edge that holds the strobe low
            if (cnt_q == 9'd0) begin
                bus_clk_d  = 1'b0;
                bus_addr_d = slot_addr;
                bus_data_d = slot_data;
            end
            if (cnt_q == C_HALF) begin
                bus_clk_d = 1'b1;
            end
            if (cnt_q == C_LAST) begin
                cnt_d   = 9'd0;
                state_d = slot_next;
                if (state_q == ST_SYNC) begin
                    needs_sync_d = 1'b0;
                end
                if (state_q == ST_DONE) begin
                    needs_sync_d = 1'b1;
                    done_sent_d  = 1'b1;
                end
            end
        end

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 9'd0;
            addr_q       <= 5'd0;
            data_q       <= 9'd0;
            needs_sync_q <= 1'b1;
            done_sent_q  <= 1'b0;
            ready_q      <= 1'b1;
            err_q        <= 1'b0;
            bus_addr_q   <= C_ADDR_SYNC;
            bus_data_q   <= 3'd0;
            bus_clk_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            needs_sync_q <= needs_sync_d;
            done_sent_q  <= done_sent_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            bus_addr_q   <= bus_addr_d;
            bus_data_q   <= bus_data_d;
            bus_clk_q    <= bus_clk_d;
        end
    end

    assign WR_READY = ready_q;
    assign ERR      = err_q;
    assign BUS_ADDR = bus_addr_q;
    assign BUS_DATA = bus_data_q;
    assign BUS_CLK  = bus_clk_q;

endmodule
`default_nettype wire

// File: tb/tb_maze_cell_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_cell_tx
// Description : Directed self-checking bench for maze_cell_tx. Records every
//               BUS_CLK rise and feeds a small receiver model that rebuilds
//               cell words from sync/lead/data/tail strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_cell_tx;

    localparam int STROBE_HALF = 4;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       WR_VALID = 1'b0;
    logic [4:0] WR_ADDR = 5'd0;
    logic [8:0] WR_DATA = 9'd0;
    logic       DONE_REQ = 1'b0;
    logic       WR_READY;
    logic       ERR;
    logic [2:0] BUS_DATA;
    logic       BUS_CLK;
    logic [4:0] BUS_ADDR;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rises[$];
    logic [7:0] exp_q[$];

    // receiver model
    int         rx_pos = 0;
    logic [8:0] rx_word = 9'd0;
    logic [8:0] rx_mem[32];

    maze_cell_tx #(.STROBE_HALF(STROBE_HALF)) u_dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .WR_VALID (WR_VALID),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .WR_READY (WR_READY),
        .DONE_REQ (DONE_REQ),
        .ERR      (ERR),
        .BUS_DATA (BUS_DATA),
        .BUS_CLK  (BUS_CLK),
        .BUS_ADDR (BUS_ADDR)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge BUS_CLK) begin
        rises.push_back({BUS_ADDR, BUS_DATA});
        if (BUS_ADDR == 5'd31) begin
            rx_pos = 0;
        end else if (BUS_ADDR != 5'd30) begin
            case (rx_pos)
                0: begin rx_word = 9'd0; rx_pos = 1; end
                1: begin rx_word[2:0] = BUS_DATA; rx_pos = 2; end
                2: begin rx_word[5:3] = BUS_DATA; rx_pos = 3; end
                3: begin rx_word[8:6] = BUS_DATA; rx_pos = 4; end
                default: begin rx_mem[BUS_ADDR] = rx_word; rx_pos = 0; end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare_rises(input string tag);
        check({tag, "_nrises"}, rises.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rises.size())
                check($sformatf("%s_rise%0d", tag, i), {24'd0, rises[i]}, {24'd0, exp_q[i]});
        end
    endtask

    // Called at a negedge; returns at a negedge with WR_READY high
    task automatic wait_ready();
        int n = 0;
        while (!WR_READY && n < 500) begin
            @(negedge CLOCK);
            n++;
        end
        if (!WR_READY) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_write(input logic [4:0] a, input logic [8:0] d);
        wait_ready();
        WR_VALID = 1'b1;
        WR_ADDR  = a;
        WR_DATA  = d;
        @(posedge CLOCK);
        #1 WR_VALID = 1'b0;
    endtask

    task automatic count_busy(output int low);
        low = 0;
        @(negedge CLOCK);
        while (!WR_READY && low < 1000) begin
            low++;
            @(negedge CLOCK);
        end
    endtask

    task automatic exp_frame(input logic [4:0] a, input logic [8:0] d, input bit sync);
        exp_q.delete();
        if (sync) exp_q.push_back({5'd31, 3'd0});
        exp_q.push_back({a, 3'd0});
        exp_q.push_back({a, d[2:0]});
        exp_q.push_back({a, d[5:3]});
        exp_q.push_back({a, d[8:6]});
        exp_q.push_back({a, 3'd0});
    endtask

    initial begin
        int low;
        int n;
        for (int i = 0; i < 32; i++) rx_mem[i] = 9'd0;

        repeat (3) @(negedge CLOCK);
        check("rst_ready", WR_READY, 1);
        check("rst_err", ERR, 0);
        check("rst_clk", BUS_CLK, 0);
        check("rst_addr", BUS_ADDR, 31);
        check("rst_data", BUS_DATA, 0);
        RESET = 1'b0;
        @(negedge CLOCK);

        // write with sync
        rises.delete();
        start_write(5'd7, 9'h1A5);
        count_busy(low);
        check("w7_busy", low, 48);
        exp_q = '{8'hF8, 8'h38, 8'h3D, 8'h3C, 8'h3E, 8'h38};
        compare_rises("w7");
        check("w7_mem", rx_mem[7], 9'h1A5);

        // back-to-back write, no sync
        rises.delete();
        start_write(5'd19, 9'h1FF);
        count_busy(low);
        check("w19_busy", low, 40);
        exp_q = '{8'h98, 8'h9F, 8'h9F, 8'h9F, 8'h98};
        compare_rises("w19");
        check("w19_mem", rx_mem[19], 9'h1FF);

        // held done request: exactly one strobe
        rises.delete();
        DONE_REQ = 1'b1;
        low = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLOCK);
            if (!WR_READY) low++;
        end
        DONE_REQ = 1'b0;
        check("done_busy", low, 2 * STROBE_HALF);
        exp_q = '{8'hF0};
        compare_rises("done");
        check("done_clk_low", BUS_CLK, 0);
        check("done_ready", WR_READY, 1);

        // write after done must resync
        rises.delete();
        start_write(5'd0, 9'h0AB);
        count_busy(low);
        check("w0_busy", low, 48);
        exp_frame(5'd0, 9'h0AB, 1'b1);
        compare_rises("w0");
        check("w0_mem", rx_mem[0], 9'h0AB);

        // reserved addresses
        rises.delete();
        start_write(5'd31, 9'h123);
        @(negedge CLOCK);
        check("err31_pulse", ERR, 1);
        check("err31_ready", WR_READY, 1);
        @(negedge CLOCK);
        check("err31_clear", ERR, 0);
        start_write(5'd30, 9'h055);
        @(negedge CLOCK);
        check("err30_pulse", ERR, 1);
        repeat (20) @(negedge CLOCK);
        check("err_ready", WR_READY, 1);
        check("err_nrises", rises.size(), 0);

        // reset during D1 slot (no sync, so D1 is the third rise)
        rises.delete();
        start_write(5'd5, 9'h155);
        n = 0;
        while (rises.size() < 3 && n < 500) begin
            @(negedge CLOCK);
            n++;
        end
        check("mid_reached_d1", rises.size(), 3);
        check("mid_clk_high", BUS_CLK, 1);
        #2 RESET = 1'b1;
        #1;
        check("mid_rst_clk", BUS_CLK, 0);
        check("mid_rst_addr", BUS_ADDR, 31);
        check("mid_rst_data", BUS_DATA, 0);
        check("mid_rst_ready", WR_READY, 1);
        @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);
        check("mid_no_commit", rx_mem[5], 9'h000);
        rises.delete();
        start_write(5'd5, 9'h155);
        count_busy(low);
        check("mid_busy", low, 48);
        exp_frame(5'd5, 9'h155, 1'b1);
        compare_rises("mid");
        check("mid_mem", rx_mem[5], 9'h155);

        // write and done together: write first, then done
        rises.delete();
        WR_VALID = 1'b1;
        WR_ADDR  = 5'd12;
        WR_DATA  = 9'h0C3;
        DONE_REQ = 1'b1;
        @(posedge CLOCK);
        #1 WR_VALID = 1'b0;
        low = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLOCK);
            if (!WR_READY) low++;
        end
        DONE_REQ = 1'b0;
        check("both_busy", low, 48);
        exp_q = '{8'h60, 8'h63, 8'h60, 8'h63, 8'h60, 8'hF0};
        compare_rises("both");
        check("both_mem", rx_mem[12], 9'h0C3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
